// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one registered 8x8 multiplier among NumReq requesters
module mul_share_arbiter #(
    parameter int NumReq = 4,
    parameter int IdW    = $clog2(NumReq)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumReq-1:0]      req_valid_i,
    output logic [NumReq-1:0]      req_ready_o,
    input  logic [NumReq-1:0][7:0] req_a_i,
    input  logic [NumReq-1:0][7:0] req_b_i,
    output logic [NumReq-1:0]      rsp_valid_o,
    input  logic [NumReq-1:0]      rsp_ready_i,
    output logic [NumReq-1:0][15:0] rsp_data_o,
    output logic [7:0]             mul_a_o,
    output logic [7:0]             mul_b_o,
    input  logic [15:0]            mul_result_i,
    input  logic                   mul_valid_i,
    output logic                   busy_o
);
    logic              inflight_q;
    logic [IdW-1:0]    inflight_id_q;
    logic [IdW-1:0]    rr_ptr_q;
    logic [IdW-1:0]    gnt_id;
    logic [IdW-1:0]    idx;
    logic [IdW-1:0]    rr_next;
    logic [IdW:0]      sum;
    logic              found;
    logic [NumReq-1:0] cap_mask;
    logic [NumReq-1:0] elig;

    assign cap_mask    = inflight_q ? (NumReq'(1) << inflight_id_q) : '0;
    assign elig        = req_valid_i & ~(cap_mask | rsp_valid_o);
    assign busy_o      = inflight_q | (|rsp_valid_o);
    assign rr_next     = (gnt_id == IdW'(NumReq - 1)) ? '0 : gnt_id + IdW'(1);
    assign req_ready_o = found ? (NumReq'(1) << gnt_id) : '0;
    assign mul_a_o     = found ? req_a_i[gnt_id] : '0;
    assign mul_b_o     = found ? req_b_i[gnt_id] : '0;

    // First eligible requester at or after rr_ptr_q, wrapping; nothing is granted while reset is held
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        idx    = '0;
        sum    = '0;
        for (int k = 0; k < NumReq; k++) begin
            sum = {1'b0, rr_ptr_q} + (IdW+1)'(k);
            if (sum >= (IdW+1)'(NumReq)) sum = sum - (IdW+1)'(NumReq);
            idx = sum[IdW-1:0];
            if (!found && elig[idx] && rst_ni) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
    end

    // Track the tag riding through the multiplier register and advance the pointer past each grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q    <= 1'b0;
            inflight_id_q <= '0;
            rr_ptr_q      <= '0;
        end else begin
            inflight_q <= found;
            if (found) begin
                inflight_id_q <= gnt_id;
                rr_ptr_q      <= rr_next;
            end
        end
    end

    // Per-requester response slots: capture the product for the in-flight tag, clear on consumer pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
        end else begin
            rsp_valid_o <= (rsp_valid_o & ~rsp_ready_i) | cap_mask;
            if (inflight_q) rsp_data_o[inflight_id_q] <= mul_result_i;
        end
    end

    // The shared multiplier must be producing whenever a tag is in flight
    assert property (@(posedge clk_i) disable iff (!rst_ni) inflight_q |-> mul_valid_i);
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: scoreboard bench for the shared-multiplier arbiter
module tb_mul_share_arbiter;
    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0][7:0] req_a = '0;
    logic [N-1:0][7:0] req_b = '0;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready = '0;
    logic [N-1:0][15:0] rsp_data;
    logic [7:0]        mul_a, mul_b;
    logic [15:0]       mul_result;
    logic              busy;
    logic              done = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ptr = 0;
    int issue_cyc [N];
    logic [N-1:0] busy_m = '0;
    logic [15:0] exp_q [N][$];

    mul_share_arbiter #(.NumReq(N)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .mul_a_o(mul_a), .mul_b_o(mul_b),
        .mul_result_i(mul_result), .mul_valid_i(rst_ni),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Registered multiplier as the parent would instantiate it
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) mul_result <= '0;
        else mul_result <= 16'(mul_a) * 16'(mul_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: reference arbitration model and per-requester scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        int g;
        int j;
        logic [N-1:0] exp_v;
        if (!rst_ni) begin
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_mul_a", 32'(mul_a), 0);
            ptr = 0;
            busy_m = '0;
            for (int i = 0; i < N; i++) exp_q[i].delete();
        end else begin
            cyc++;
            g = -1;
            for (int k = 0; k < N; k++) begin
                j = (ptr + k) % N;
                if (g < 0 && req_valid[j] && !busy_m[j]) g = j;
            end
            chk("ready", 32'(req_ready), g >= 0 ? (32'd1 << g) : 32'd0);
            chk("mul_a", 32'(mul_a), g >= 0 ? 32'(req_a[g]) : 32'd0);
            chk("mul_b", 32'(mul_b), g >= 0 ? 32'(req_b[g]) : 32'd0);
            for (int i = 0; i < N; i++) exp_v[i] = busy_m[i] && (cyc >= issue_cyc[i] + 2);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
            chk("busy", 32'(busy), 32'(|busy_m));
            for (int i = 0; i < N; i++) begin
                if (exp_v[i] && exp_q[i].size() > 0) begin
                    chk($sformatf("rsp_data%0d", i), 32'(rsp_data[i]), 32'(exp_q[i][0]));
                    if (rsp_ready[i]) begin
                        void'(exp_q[i].pop_front());
                        busy_m[i] = 1'b0;
                    end
                end
            end
            if (g >= 0) begin
                busy_m[g] = 1'b1;
                issue_cyc[g] = cyc;
                exp_q[g].push_back(16'(req_a[g]) * 16'(req_b[g]));
                ptr = (g + 1) % N;
            end
            if (done) begin
                for (int i = 0; i < N; i++) chk("drain", exp_q[i].size(), 0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Stimulus: directed scenarios then random traffic
    initial begin
        tick(3);
        rst_ni = 1'b1;
        rsp_ready = '1;
        req_a[0] = 8'hFF; req_b[0] = 8'hFF; req_valid = 4'b0001;
        tick(4);
        req_valid = '0;
        tick(4);
        for (int i = 0; i < N; i++) begin
            req_a[i] = 8'(i + 1);
            req_b[i] = 8'h10;
        end
        req_valid = '1;
        tick(20);
        req_valid = '0;
        tick(4);
        req_a[1] = 8'h33; req_b[1] = 8'h05; req_a[2] = 8'h09; req_b[2] = 8'h03;
        rsp_ready = 4'b1101;
        req_valid = 4'b0110;
        tick(10);
        rsp_ready = '1;
        tick(3);
        req_valid = '0;
        tick(4);
        req_valid = 4'b0100;
        tick(1);
        req_valid = '0;
        tick(3);
        req_valid = 4'b1001;
        tick(8);
        req_valid = '0;
        tick(4);
        req_a[2] = 8'd7; req_b[2] = 8'd9; req_valid = 4'b0100;
        tick(1);
        req_valid = '0;
        rst_ni = 1'b0;
        tick(2);
        rst_ni = 1'b1;
        tick(5);
        req_a[0] = 8'h00; req_b[0] = 8'hAB;
        req_a[1] = 8'h80; req_b[1] = 8'h02;
        req_a[3] = 8'h01; req_b[3] = 8'h01;
        req_valid = 4'b1011;
        tick(1);
        req_valid = '0;
        tick(5);
        repeat (1500) begin
            req_valid = 4'($urandom);
            rsp_ready = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                req_a[i] = 8'($urandom);
                req_b[i] = 8'($urandom);
            end
            tick(1);
        end
        req_valid = '0;
        rsp_ready = '1;
        tick(5);
        done = 1'b1;
    end
endmodule
